fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Sequences instruction fetch for the 2-issue front end. It owns the fetch PC, issues 8-byte-aligned requests to the icache with one request outstanding, and buffers returned 64-bit packets in a small fetch queue. Each packet is presented to decode with its PC and 2-bit slot-valid mask. Backend redirects flush the queue and discard stale in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded at reset
FQ_DEPTH, 4, fetch queue entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_redirect_vld  in  1  backend redirect (branch/jump/exception)
i_redirect_pc  in  32  redirect target; bits [1:0] ignored
o_icache_req  out  1  fetch request valid
o_icache_addr  out  32  request address, {pc[31:3],3'b000}
i_icache_ack  in  1  request accepted this cycle
i_icache_vld  in  1  response data valid (arrives >=1 cycle after ack)
i_icache_dat  in  64  response data; [31:0] slot 0, [63:32] slot 1
o_pkt_vld  out  1  queue head valid
o_pc  out  32  head packet fetch PC
o_instr  out  64  head packet data
o_instr_vld  out  2  head slot mask
i_dec_rdy  in  1  decode accepts head this cycle

Behaviour:
- Reset is asynchronous on rst_n low: pc=RESET_PC with [1:0]=0, state=REQ, queue empty, o_pkt_vld=0, o_icache_req=0, o_pc/o_instr/o_instr_vld=0.
- FSM states:
  - REQ: o_icache_req=1 iff queue count<FQ_DEPTH. On ack: capture req_pc=pc, pc<={pc[31:3]+1,3'b000}, go to WAIT.
  - WAIT: o_icache_req=0. On i_icache_vld: push {req_pc, dat, mask}, go to REQ.
  - DRAIN: o_icache_req=0. On i_icache_vld: discard the response, go to REQ.
- Mask: mask[0]=~req_pc[2], mask[1]=1. A target with pc[2]=1 invalidates slot 0.
- Push timing: a response in cycle M is visible at o_pkt_vld in cycle M+1. Queue output comes from registered storage; no bypass.
- Pop: o_pkt_vld & i_dec_rdy. Push and pop in the same cycle are both allowed; count is unchanged.
- Full: no request is issued while count==FQ_DEPTH. With one request outstanding, a response always finds space.
- Redirect (highest priority, takes effect at the clock edge):
  - pc<={i_redirect_pc[31:2],2'b00}.
  - Queue is flushed; any same-cycle pop or push is ignored; o_pkt_vld=0 in the next cycle.
  - REQ without ack: stay in REQ; next cycle requests the new PC.
  - REQ with ack in the same cycle: the accepted request is stale; go to DRAIN.
  - WAIT without vld: go to DRAIN.
  - WAIT with vld in the same cycle: drop the response; go to REQ.
  - DRAIN: stay in DRAIN; the new pc is kept.
- Sequential PC wrap: 32'hFFFF_FFF8 -> 32'h0000_0000.
- Counters: pointers are log2(FQ_DEPTH) bits and wrap naturally; count is log2(FQ_DEPTH)+1 bits.
- Outputs when o_pkt_vld=0: o_instr_vld=2'b00. o_pc/o_instr are don't-care.

Decomposition:
- fetch_pkg:
  - fetch_pkt_t struct {logic [31:0] pc; logic [63:0] instr; logic [1:0] vld;}.
  - fetch_state_t enum {REQ, WAIT, DRAIN}.
  - Constant FETCH_BYTES=8.
- Sub-module fetch_queue: a parameterised synchronous FIFO of fetch_pkt_t.
  - Inputs: push, pop, flush.
  - Outputs: empty, full, count.
- fetch_ctrl holds the FSM, PC and mask logic.

Test Plan:
- Reset, ack always 1, vld one cycle after ack, dec_rdy=1 -> addresses 0x0,0x8,0x10,...; each packet has o_instr_vld=2'b11; o_pc matches its address.
- Redirect to 0x104 while in REQ -> next o_icache_addr=0x100; packet o_pc=0x104, o_instr_vld=2'b10; next fetch 0x108 with mask 2'b11.
- dec_rdy=0 held, FQ_DEPTH=4 -> exactly 4 requests issued, then o_icache_req=0. Raise dec_rdy -> one pop per cycle, requests resume.
- Redirect to 0x200 in WAIT, stale vld (data 0xDEAD) 3 cycles later -> stale data is never presented; next request addr=0x200; queue empty in the meantime.
- Redirect in the same cycle as ack -> DRAIN entered, following response discarded, then a request to the target is issued. Redirect in the same cycle as vld -> response dropped, no DRAIN.
- rst_n asserted mid-WAIT, asynchronously and off the clock edge -> outputs clear immediately. After release, first o_icache_addr=RESET_PC; a late response is ignored (verify with vld gated to 0).

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch front end
package fetch_pkg;

   localparam logic [31:0] FETCH_BYTES = 32'd8;

   typedef struct packed {
      logic [31:0] pc;
      logic [63:0] instr;
      logic [1:0]  vld;
   } fetch_pkt_t;

   typedef enum logic [1:0] {
      REQ   = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

   // Slot 1 is always live; slot 0 is dead when the fetch PC lands on the upper word.
   function automatic logic [1:0] slot_mask(input logic pc_bit2);
      return {1'b1, ~pc_bit2};
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous FIFO of fetch packets with flush
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  fetch_pkt_t               din,
   output fetch_pkt_t               dout,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   fetch_pkt_t      mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop & ~flush & ~empty;
   assign do_push = push & ~flush & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch PC sequencing, single-outstanding icache requests, redirect handling
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          FQ_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_redirect_vld,
   input  logic [31:0]   i_redirect_pc,
   output logic          o_icache_req,
   output logic [31:0]   o_icache_addr,
   input  logic          i_icache_ack,
   input  logic          i_icache_vld,
   input  logic [63:0]   i_icache_dat,
   output logic          o_pkt_vld,
   output logic [31:0]   o_pc,
   output logic [63:0]   o_instr,
   output logic [1:0]    o_instr_vld,
   input  logic          i_dec_rdy
);

   localparam int CW = $clog2(FQ_DEPTH) + 1;

   localparam logic [1:0] S_REQ   = 2'(REQ);
   localparam logic [1:0] S_WAIT  = 2'(WAIT);
   localparam logic [1:0] S_DRAIN = 2'(DRAIN);

   logic [1:0]    state;
   logic [31:0]   pc;
   logic [31:0]   req_pc;
   logic          accepted;
   logic          resp;
   logic          q_push;
   logic          q_pop;
   logic          q_empty;
   logic          q_full;
   logic [CW-1:0] q_count;
   logic          room;
   fetch_pkt_t    q_din;
   fetch_pkt_t    q_head;

   assign room          = (q_count < CW'(FQ_DEPTH)) & ~q_full;
   assign o_icache_req  = rst_n & (state == S_REQ) & room;
   assign o_icache_addr = {pc[31:3], 3'b000};
   assign accepted      = o_icache_req & i_icache_ack;
   assign resp          = (state == S_WAIT) & i_icache_vld;

   // A redirect kills both ends of the queue in the same cycle it flushes it.
   assign q_push = resp & ~i_redirect_vld;
   assign q_pop  = o_pkt_vld & i_dec_rdy & ~i_redirect_vld;

   assign q_din.pc    = req_pc;
   assign q_din.instr = i_icache_dat;
   assign q_din.vld   = slot_mask(req_pc[2]);

   fetch_queue #(
      .DEPTH (FQ_DEPTH)
   ) u_queue (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (q_push),
      .pop   (q_pop),
      .flush (i_redirect_vld),
      .din   (q_din),
      .dout  (q_head),
      .empty (q_empty),
      .full  (q_full),
      .count (q_count)
   );

   assign o_pkt_vld   = ~q_empty;
   assign o_pc        = o_pkt_vld ? q_head.pc    : '0;
   assign o_instr     = o_pkt_vld ? q_head.instr : '0;
   assign o_instr_vld = o_pkt_vld ? q_head.vld   : 2'b00;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_REQ;
         pc     <= RESET_PC & 32'hFFFF_FFFC;
         req_pc <= '0;
      end else begin
         if (accepted) begin
            req_pc <= pc;
         end
         if (i_redirect_vld) begin
            pc <= i_redirect_pc & 32'hFFFF_FFFC;
            // Anything already accepted by the icache belongs to the old path and must be drained.
            case (state)
               S_REQ:   state <= accepted ? S_DRAIN : S_REQ;
               S_WAIT:  state <= i_icache_vld ? S_REQ : S_DRAIN;
               S_DRAIN: state <= i_icache_vld ? S_REQ : S_DRAIN;
               default: state <= S_REQ;
            endcase
         end else begin
            case (state)
               S_REQ: begin
                  if (accepted) begin
                     pc    <= o_icache_addr + FETCH_BYTES;
                     state <= S_WAIT;
                  end
               end
               S_WAIT: begin
                  if (i_icache_vld) begin
                     state <= S_REQ;
                  end
               end
               S_DRAIN: begin
                  if (i_icache_vld) begin
                     state <= S_REQ;
                  end
               end
               default: state <= S_REQ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl against a packet-level reference model
module tb_fetch_ctrl;

   localparam logic [63:0] STALE = 64'h0000_DEAD_0000_DEAD;

   logic          clk;
   logic          rst_n;
   logic          i_redirect_vld;
   logic [31:0]   i_redirect_pc;
   logic          o_icache_req;
   logic [31:0]   o_icache_addr;
   logic          i_icache_ack;
   logic          i_icache_vld;
   logic [63:0]   i_icache_dat;
   logic          o_pkt_vld;
   logic [31:0]   o_pc;
   logic [63:0]   o_instr;
   logic [1:0]    o_instr_vld;
   logic          i_dec_rdy;

   fetch_ctrl #(
      .RESET_PC (32'h0000_0000),
      .FQ_DEPTH (4)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_redirect_vld (i_redirect_vld),
      .i_redirect_pc  (i_redirect_pc),
      .o_icache_req   (o_icache_req),
      .o_icache_addr  (o_icache_addr),
      .i_icache_ack   (i_icache_ack),
      .i_icache_vld   (i_icache_vld),
      .i_icache_dat   (i_icache_dat),
      .o_pkt_vld      (o_pkt_vld),
      .o_pc           (o_pc),
      .o_instr        (o_instr),
      .o_instr_vld    (o_instr_vld),
      .i_dec_rdy      (i_dec_rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [63:0] d;
      logic [1:0]  m;
   } mpkt_t;

   mpkt_t         mq[$];
   logic [31:0]   acc[$];
   logic [31:0]   pop_pc[$];
   logic [1:0]    pop_m[$];
   logic [31:0]   exp_pc;
   logic [31:0]   req_pc_m;
   logic          outstanding;
   logic          stale;
   int            lat;
   int            lat_min;
   int            lat_max;
   int            checks;
   int            errors;
   int            dead_seen;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cycle(input logic redir, input logic [31:0] tgt, input int ack_pct, input int rdy_pct);
      logic        ack;
      logic        vld;
      logic        rdy;
      logic [63:0] dat;
      mpkt_t       p;
      @(negedge clk);
      chk("icache_req", 64'(o_icache_req), 64'(!outstanding && mq.size() < 4));
      if (o_icache_req) chk("icache_addr", 64'(o_icache_addr), 64'(exp_pc & 32'hFFFF_FFF8));
      chk("pkt_vld", 64'(o_pkt_vld), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
         chk("head_pc", 64'(o_pc), 64'(mq[0].pc));
         chk("head_instr", o_instr, mq[0].d);
         chk("head_mask", 64'(o_instr_vld), 64'(mq[0].m));
         if (o_instr === STALE) dead_seen++;
      end else begin
         chk("idle_mask", 64'(o_instr_vld), 64'(2'b00));
      end
      ack = o_icache_req && ($urandom_range(0, 99) < ack_pct);
      vld = 1'b0;
      if (outstanding) begin
         if (lat <= 1) vld = 1'b1;
         else lat--;
      end
      dat = stale ? STALE : {$urandom, $urandom};
      rdy = ($urandom_range(0, 99) < rdy_pct);
      i_redirect_vld = redir;
      i_redirect_pc  = tgt;
      i_icache_ack   = ack;
      i_icache_vld   = vld;
      i_icache_dat   = dat;
      i_dec_rdy      = rdy;
      if (mq.size() != 0 && rdy && !redir) begin
         pop_pc.push_back(o_pc);
         pop_m.push_back(o_instr_vld);
      end
      if (ack) acc.push_back(o_icache_addr);
      if (redir) begin
         mq.delete();
         exp_pc = tgt & 32'hFFFF_FFFC;
         if (vld) begin
            outstanding = 1'b0;
            stale = 1'b0;
         end else if (outstanding) begin
            stale = 1'b1;
         end
         if (ack) begin
            outstanding = 1'b1;
            stale = 1'b1;
            lat = int'($urandom_range(lat_min, lat_max));
         end
      end else begin
         if (mq.size() != 0 && rdy) p = mq.pop_front();
         if (vld) begin
            if (!stale) begin
               p.pc = req_pc_m;
               p.d  = dat;
               p.m  = {1'b1, ~req_pc_m[2]};
               mq.push_back(p);
            end
            outstanding = 1'b0;
            stale = 1'b0;
         end
         if (ack) begin
            req_pc_m = exp_pc;
            exp_pc = (exp_pc & 32'hFFFF_FFF8) + 32'd8;
            outstanding = 1'b1;
            stale = 1'b0;
            lat = int'($urandom_range(lat_min, lat_max));
         end
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 20 && outstanding; i++) cycle(1'b0, 32'h0, 0, 100);
      chk("idle_timeout", 64'(outstanding), 64'(1'b0));
   endtask

   task automatic wait_ack();
      for (int i = 0; i < 20 && !outstanding; i++) cycle(1'b0, 32'h0, 100, 100);
      chk("ack_timeout", 64'(outstanding), 64'(1'b1));
   endtask

   task automatic run_until_acc(input int n);
      for (int i = 0; i < 40 && acc.size() < n; i++) cycle(1'b0, 32'h0, 100, 100);
      chk("acc_timeout", 64'(acc.size() >= n), 64'(1'b1));
   endtask

   initial begin
      checks = 0; errors = 0; dead_seen = 0;
      outstanding = 1'b0; stale = 1'b0; lat = 0;
      lat_min = 1; lat_max = 1;
      exp_pc = 32'h0; req_pc_m = 32'h0;
      rst_n = 1'b0;
      i_redirect_vld = 1'b0; i_redirect_pc = 32'h0;
      i_icache_ack = 1'b0; i_icache_vld = 1'b0; i_icache_dat = 64'h0; i_dec_rdy = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", 64'(o_icache_req), 64'(1'b0));
      chk("rst_pkt_vld", 64'(o_pkt_vld), 64'(1'b0));
      chk("rst_pc", 64'(o_pc), 64'(32'h0));
      chk("rst_instr", o_instr, 64'h0);
      chk("rst_mask", 64'(o_instr_vld), 64'(2'b00));
      @(negedge clk);
      rst_n = 1'b1;

      // sequential stream, ack always, one-cycle response, decode always ready
      acc.delete(); pop_pc.delete(); pop_m.delete();
      repeat (12) cycle(1'b0, 32'h0, 100, 100);
      chk("seq_addr0", 64'(acc[0]), 64'(32'h0));
      chk("seq_addr1", 64'(acc[1]), 64'(32'h8));
      chk("seq_addr2", 64'(acc[2]), 64'(32'h10));
      chk("seq_pop_pc0", 64'(pop_pc[0]), 64'(32'h0));
      chk("seq_pop_m0", 64'(pop_m[0]), 64'(2'b11));
      chk("seq_pop_m1", 64'(pop_m[1]), 64'(2'b11));

      // redirect to an upper-word target while idle in REQ
      wait_idle();
      cycle(1'b1, 32'h0000_0104, 0, 100);
      acc.delete(); pop_pc.delete(); pop_m.delete();
      run_until_acc(1);
      chk("redir_addr", 64'(acc[0]), 64'(32'h100));
      for (int i = 0; i < 30 && pop_pc.size() < 2; i++) cycle(1'b0, 32'h0, 100, 100);
      chk("redir_pop_pc0", 64'(pop_pc[0]), 64'(32'h104));
      chk("redir_pop_m0", 64'(pop_m[0]), 64'(2'b10));
      chk("redir_pop_pc1", 64'(pop_pc[1]), 64'(32'h108));
      chk("redir_pop_m1", 64'(pop_m[1]), 64'(2'b11));

      // sequential wrap at the top of the address space
      wait_idle();
      cycle(1'b1, 32'hFFFF_FFF8, 0, 100);
      acc.delete();
      run_until_acc(2);
      chk("wrap_addr0", 64'(acc[0]), 64'(32'hFFFF_FFF8));
      chk("wrap_addr1", 64'(acc[1]), 64'(32'h0));

      // decode stalled: queue fills after exactly four requests
      wait_idle();
      cycle(1'b1, 32'h0000_0300, 0, 100);
      acc.delete();
      repeat (20) cycle(1'b0, 32'h0, 100, 0);
      chk("full_req_count", 64'(acc.size()), 64'(4));
      @(posedge clk);
      #1;
      chk("full_req_low", 64'(o_icache_req), 64'(1'b0));
      chk("full_pkt_vld", 64'(o_pkt_vld), 64'(1'b1));
      pop_pc.delete(); pop_m.delete();
      repeat (4) cycle(1'b0, 32'h0, 0, 100);
      chk("drain_pops", 64'(pop_pc.size()), 64'(4));
      acc.delete();
      repeat (6) cycle(1'b0, 32'h0, 100, 100);
      chk("resume_req", 64'(acc.size() > 0), 64'(1'b1));

      // redirect in WAIT, stale response arrives three cycles later
      lat_min = 4; lat_max = 4;
      wait_idle();
      wait_ack();
      cycle(1'b1, 32'h0000_0200, 0, 100);
      acc.delete(); pop_pc.delete(); pop_m.delete();
      run_until_acc(1);
      chk("wait_redir_addr", 64'(acc[0]), 64'(32'h200));
      chk("wait_redir_nopop", 64'(pop_pc.size()), 64'(0));

      // redirect coincident with ack: stale request is drained
      lat_min = 2; lat_max = 2;
      wait_idle();
      cycle(1'b1, 32'h0000_0400, 100, 100);
      @(posedge clk);
      #1;
      chk("ack_redir_drain", 64'(o_icache_req), 64'(1'b0));
      acc.delete();
      run_until_acc(2);
      chk("ack_redir_addr", 64'(acc[0]), 64'(32'h400));

      // redirect coincident with response: no drain needed
      wait_idle();
      wait_ack();
      cycle(1'b0, 32'h0, 0, 100);
      cycle(1'b1, 32'h0000_0500, 0, 100);
      @(posedge clk);
      #1;
      chk("vld_redir_req", 64'(o_icache_req), 64'(1'b1));
      chk("vld_redir_pkt", 64'(o_pkt_vld), 64'(1'b0));
      acc.delete();
      run_until_acc(1);
      chk("vld_redir_addr", 64'(acc[0]), 64'(32'h500));

      // asynchronous reset in the middle of WAIT
      lat_min = 4; lat_max = 4;
      wait_idle();
      wait_ack();
      cycle(1'b0, 32'h0, 0, 100);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      i_redirect_vld = 1'b0; i_icache_ack = 1'b0; i_icache_vld = 1'b0; i_dec_rdy = 1'b0;
      #1;
      chk("arst_req", 64'(o_icache_req), 64'(1'b0));
      chk("arst_pkt_vld", 64'(o_pkt_vld), 64'(1'b0));
      chk("arst_mask", 64'(o_instr_vld), 64'(2'b00));
      chk("arst_instr", o_instr, 64'h0);
      mq.delete();
      outstanding = 1'b0; stale = 1'b0; exp_pc = 32'h0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      acc.delete();
      run_until_acc(1);
      chk("arst_first_addr", 64'(acc[0]), 64'(32'h0));

      // randomized traffic with random redirects, latencies and decode stalls
      lat_min = 1; lat_max = 4;
      for (int i = 0; i < 1500; i++) begin
         logic        r;
         logic [31:0] t;
         r = ($urandom_range(0, 19) == 0);
         t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
         cycle(r, t, 70, 60);
      end
      chk("stale_never_shown", 64'(dead_seen), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
